fb_access_arbiter: RTL and testbench
====================================

Name: fb_access_arbiter

Overview:
- Shares the single read/write port of the framebuffer BRAM between two requesters: the VGA controller's pixel fetch and the CPU memory pipeline stage (fb_en path).
- The VGA side has priority. A starvation guard guarantees that a CPU access completes within a bounded time.
- Drives the stall request to the hazard control unit while a CPU access is denied.
- Sits between memory_io and the framebuffer block RAM.

Parameters:
- ADDR_W, 17, framebuffer address width.
- DATA_W, 12, pixel/data width (4:4:4 RGB).
- STARVE_LIMIT, 8, number of consecutive denied CPU cycles after which the CPU is force-granted (range 1..255).

Ports:
- clock  in  1  core clock; all state updates on rising edge.
- nreset  in  1  asynchronous active-low reset.
- vga_req  in  1  VGA controller requests a pixel read this cycle.
- vga_addr  in  ADDR_W  pixel address.
- vga_data  out  DATA_W  pixel read data; holds its last value when not updated.
- vga_valid  out  1  vga_data updated this cycle.
- vga_miss  out  1  one-cycle pulse: the previous-cycle vga_req was not served.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_wen  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack on reads.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_stall_req  out  1  to the hazard unit: a CPU request is pending and not yet acknowledged.
- fb_en  out  1  BRAM port enable.
- fb_wen  out  1  BRAM write enable.
- fb_addr  out  ADDR_W  BRAM address.
- fb_din  out  DATA_W  BRAM write data.
- fb_dout  in  DATA_W  BRAM read data; 1-cycle synchronous latency.
- stat_miss_cnt  out  16  VGA miss counter (optional feature).
- stat_stall_cnt  out  16  CPU stall-cycle counter (optional feature).

Behaviour:

Reset:
- On nreset low, asynchronously clear all registered outputs, counters, the FSM (to S_IDLE) and the response tracking.
- Any in-flight response is dropped; no cpu_ack is issued for it.

Grant (combinational, per cycle):
- In S_IDLE, grant CPU if cpu_req && (starve_cnt == STARVE_LIMIT || !vga_req).
- Otherwise grant VGA if vga_req.
- In S_CPU_RESP, CPU is never granted; VGA is granted if vga_req.

Port drive:
- fb_en = any grant.
- fb_addr and fb_din come from the granted requester.
- fb_wen = CPU grant && cpu_wen.
- With no grant, fb_en = 0, fb_wen = 0, and the address/data are don't-care but driven 0.

FSM:
- S_IDLE -> S_CPU_RESP on a CPU grant.
- S_CPU_RESP -> S_IDLE unconditionally after one cycle. In that cycle the block asserts cpu_ack. For reads it also registers cpu_rdata = fb_dout.
- Consequences:
  - Latency is grant + 1 cycle for both reads and writes.
  - Minimum CPU access spacing is 2 cycles.
  - A cpu_req still high in the ack cycle is not re-granted.

CPU stall:
- cpu_stall_req = cpu_req && !cpu_ack (combinational from registered cpu_ack).
- It is therefore high in the grant cycle and low in the ack cycle.

VGA response:
- A VGA grant in cycle N gives vga_valid = 1 and vga_data = fb_dout at cycle N+1 (both registered).
- A vga_req that is not granted gives vga_valid = 0 and vga_miss = 1 at N+1; vga_data is unchanged.

Starvation counter (8 bit):
- Cleared on a CPU grant or when cpu_req = 0.
- Incremented, saturating at STARVE_LIMIT, on each cycle with cpu_req high, no CPU grant and state S_IDLE.
- The forced grant occurs on the cycle the counter equals STARVE_LIMIT.

Simultaneous events:
- A VGA request colliding with a CPU grant always yields a miss.
- Back-to-back forced grants are impossible because the counter clears on grant.

Optional Feature:
- Macro FB_ACCESS_ARB_STATS_EN.
- Defined:
  - stat_miss_cnt increments on every vga_miss pulse.
  - stat_stall_cnt increments on every cycle with cpu_stall_req = 1.
  - Both are 16-bit, saturate at 16'hFFFF and are cleared by nreset.
- Undefined:
  - Both outputs are tied to 0 and no counter registers are synthesized.
  - Ports are unchanged.

Test Plan:
1. Reset: hold nreset = 0 for 3 cycles with requests active -> all outputs 0 and state S_IDLE. Release -> first grant on the next edge.
2. CPU read, VGA idle: cpu_req = 1, cpu_wen = 0, cpu_addr = 17'h00123, BRAM holds 12'hABC -> fb_en = 1 with fb_addr = 17'h00123 in cycle 0. Cycle 1: cpu_ack = 1, cpu_rdata = 12'hABC, cpu_stall_req = 0.
3. CPU write, VGA idle: cpu_wen = 1, cpu_wdata = 12'h5A5 -> fb_wen = 1 with fb_din = 12'h5A5 for exactly one cycle. cpu_ack next cycle. No second write while cpu_req is still high in the ack cycle.
4. Starvation: vga_req held 1 continuously, cpu_req raised at cycle 0, STARVE_LIMIT = 8:
   - Cycles 0-7: VGA served, cpu_stall_req = 1.
   - Cycle 8: CPU granted.
   - Cycle 9: vga_miss = 1, vga_valid = 0, vga_data unchanged, cpu_ack = 1.
5. VGA streaming: vga_req = 1 with addresses 0..3 holding 1, 2, 3, 4 -> vga_valid = 1 on cycles 1..4 with vga_data 1, 2, 3, 4 and no misses.
6. Reset mid-access: assert nreset = 0 in the S_CPU_RESP cycle -> no cpu_ack. After release with cpu_req still high, a fresh grant follows. With FB_ACCESS_ARB_STATS_EN defined, scenario 4 ends with stat_miss_cnt = 1 and stat_stall_cnt = 9.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// Arbitrates the framebuffer BRAM port between VGA pixel fetch (priority) and CPU accesses, with a starvation guard.
// Optional statistics counters are built when FB_ACCESS_ARB_STATS_EN is defined.
module fb_access_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 12,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall_req,
    output logic              fb_en,
    output logic              fb_wen,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [DATA_W-1:0] fb_din,
    input  logic [DATA_W-1:0] fb_dout,
    output logic [15:0]       stat_miss_cnt,
    output logic [15:0]       stat_stall_cnt
);

    typedef enum logic {S_IDLE, S_CPU_RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t            state;
    logic [7:0]        starve_cnt;
    logic              grant_cpu;
    logic              grant_vga;
    logic              resp_rd;
    logic [DATA_W-1:0] vga_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    always_comb begin
        grant_cpu = (state == S_IDLE) && cpu_req && ((starve_cnt == LIMIT) || !vga_req);
        grant_vga = vga_req && !grant_cpu;
    end

    assign fb_en   = grant_cpu | grant_vga;
    assign fb_wen  = grant_cpu & cpu_wen;
    assign fb_addr = grant_cpu ? cpu_addr : (grant_vga ? vga_addr : '0);
    assign fb_din  = grant_cpu ? cpu_wdata : '0;

    // BRAM output is already registered, so read data is passed through in the response cycle and held afterwards.
    assign vga_data      = vga_valid ? fb_dout : vga_data_q;
    assign cpu_rdata     = (cpu_ack && resp_rd) ? fb_dout : cpu_rdata_q;
    assign cpu_stall_req = cpu_req && !cpu_ack;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            cpu_ack     <= 1'b0;
            resp_rd     <= 1'b0;
            vga_valid   <= 1'b0;
            vga_miss    <= 1'b0;
            vga_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE:     if (grant_cpu) state <= S_CPU_RESP;
                S_CPU_RESP: state <= S_IDLE;
                default:    state <= S_IDLE;
            endcase

            cpu_ack   <= grant_cpu;
            resp_rd   <= grant_cpu && !cpu_wen;
            vga_valid <= grant_vga;
            vga_miss  <= vga_req && !grant_vga;

            if (cpu_ack && resp_rd) cpu_rdata_q <= fb_dout;
            if (vga_valid)          vga_data_q  <= fb_dout;

            // Counter clears on grant so two forced grants can never be adjacent.
            if (grant_cpu || !cpu_req)
                starve_cnt <= '0;
            else if ((state == S_IDLE) && (starve_cnt != LIMIT))
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

`ifdef FB_ACCESS_ARB_STATS_EN
    logic [15:0] miss_cnt;
    logic [15:0] stall_cnt;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            miss_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (vga_miss && (miss_cnt != 16'hFFFF))       miss_cnt  <= miss_cnt + 16'd1;
            if (cpu_stall_req && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign stat_miss_cnt  = miss_cnt;
    assign stat_stall_cnt = stall_cnt;
`else
    assign stat_miss_cnt  = '0;
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a BRAM model and response scoreboards.
module tb_fb_access_arbiter;

    logic        clock = 1'b0;
    logic        nreset;
    logic        vga_req;
    logic [16:0] vga_addr;
    logic [11:0] vga_data;
    logic        vga_valid;
    logic        vga_miss;
    logic        cpu_req;
    logic        cpu_wen;
    logic [16:0] cpu_addr;
    logic [11:0] cpu_wdata;
    logic [11:0] cpu_rdata;
    logic        cpu_ack;
    logic        cpu_stall_req;
    logic        fb_en;
    logic        fb_wen;
    logic [16:0] fb_addr;
    logic [11:0] fb_din;
    logic [11:0] fb_dout;
    logic [15:0] stat_miss_cnt;
    logic [15:0] stat_stall_cnt;

    typedef struct {
        logic        rd;
        logic [11:0] data;
    } cpu_exp_t;

    logic [11:0] vga_q[$];
    cpu_exp_t    cpu_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic        load_en;
    logic [9:0]  load_addr;
    logic [11:0] load_data;
    logic [11:0] mem [0:1023];

    logic [9:0]  pre_addr [5] = '{10'h000, 10'h001, 10'h002, 10'h003, 10'h123};
    logic [11:0] pre_data [5] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'hABC};
    logic [16:0] str_addr [5] = '{17'h00000, 17'h00001, 17'h00002, 17'h00003, 17'h00050};
    logic [11:0] str_data [5] = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h5A5};

    fb_access_arbiter #(.ADDR_W(17), .DATA_W(12), .STARVE_LIMIT(8)) dut (
        .clock(clock), .nreset(nreset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
        .vga_valid(vga_valid), .vga_miss(vga_miss),
        .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .cpu_stall_req(cpu_stall_req),
        .fb_en(fb_en), .fb_wen(fb_wen), .fb_addr(fb_addr), .fb_din(fb_din),
        .fb_dout(fb_dout),
        .stat_miss_cnt(stat_miss_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clock = ~clock;

    // Single-port BRAM with one cycle read latency; preload port for setup.
    always @(posedge clock) begin
        if (load_en)
            mem[load_addr] <= load_data;
        else if (fb_en) begin
            if (fb_wen) mem[fb_addr[9:0]] <= fb_din;
            else        fb_dout <= mem[fb_addr[9:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic mid();
        @(negedge clock);
    endtask

    // Response scoreboards
    always @(negedge clock) begin
        if (nreset === 1'b1) begin
            if (vga_valid === 1'b1) begin
                chk("sb_vga_pending", 32'(vga_q.size() != 0), 32'd1);
                if (vga_q.size() != 0) chk("sb_vga_data", vga_data, vga_q.pop_front());
            end
            if (cpu_ack === 1'b1) begin
                chk("sb_cpu_pending", 32'(cpu_q.size() != 0), 32'd1);
                if (cpu_q.size() != 0) begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    if (e.rd) chk("sb_cpu_rdata", cpu_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset = 1'b0; vga_req = 1'b0; vga_addr = '0;
        cpu_req = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        for (int i = 0; i < 5; i++) begin
            tick();
            load_en = 1'b1; load_addr = pre_addr[i]; load_data = pre_data[i];
        end
        tick();
        load_en = 1'b0;

        // Reset held with both requesters active
        vga_req = 1'b1; vga_addr = 17'h00000;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 17'h00123;
        for (int c = 0; c < 3; c++) begin
            mid();
            chk("rst_vga_valid", vga_valid, 0);
            chk("rst_vga_miss", vga_miss, 0);
            chk("rst_cpu_ack", cpu_ack, 0);
            chk("rst_vga_data", vga_data, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_stat_miss", stat_miss_cnt, 0);
            chk("rst_stat_stall", stat_stall_cnt, 0);
            tick();
        end
        nreset = 1'b1; cpu_req = 1'b0;
        vga_q.push_back(12'h001);
        mid();
        chk("rel_fb_en", fb_en, 1);
        chk("rel_fb_addr", fb_addr, 17'h00000);
        chk("rel_fb_wen", fb_wen, 0);
        tick();
        vga_req = 1'b0;
        mid();
        chk("rel_vga_valid", vga_valid, 1);
        chk("rel_vga_data", vga_data, 12'h001);
        chk("rel_vga_miss", vga_miss, 0);

        // CPU read, VGA idle
        tick();
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 17'h00123;
        cpu_q.push_back('{1'b1, 12'hABC});
        mid();
        chk("rd_fb_en", fb_en, 1);
        chk("rd_fb_addr", fb_addr, 17'h00123);
        chk("rd_fb_wen", fb_wen, 0);
        chk("rd_stall_grant", cpu_stall_req, 1);
        tick();
        mid();
        chk("rd_ack", cpu_ack, 1);
        chk("rd_rdata", cpu_rdata, 12'hABC);
        chk("rd_stall_ack", cpu_stall_req, 0);
        chk("rd_no_regrant", fb_en, 0);
        tick();
        cpu_req = 1'b0;
        mid();
        chk("rd_ack_pulse", cpu_ack, 0);
        chk("rd_rdata_hold", cpu_rdata, 12'hABC);

        // CPU write, VGA idle
        tick();
        cpu_req = 1'b1; cpu_wen = 1'b1; cpu_addr = 17'h00050; cpu_wdata = 12'h5A5;
        cpu_q.push_back('{1'b0, 12'h000});
        mid();
        chk("wr_fb_en", fb_en, 1);
        chk("wr_fb_wen", fb_wen, 1);
        chk("wr_fb_din", fb_din, 12'h5A5);
        chk("wr_fb_addr", fb_addr, 17'h00050);
        tick();
        mid();
        chk("wr_ack", cpu_ack, 1);
        chk("wr_no_second_wen", fb_wen, 0);
        chk("wr_no_second_en", fb_en, 0);
        chk("wr_rdata_hold", cpu_rdata, 12'hABC);
        tick();
        cpu_req = 1'b0; cpu_wen = 1'b0;
        mid();
        chk("wr_ack_pulse", cpu_ack, 0);

        // VGA streaming, including readback of the CPU write
        for (int i = 0; i < 5; i++) begin
            tick();
            vga_req = 1'b1; vga_addr = str_addr[i];
            vga_q.push_back(str_data[i]);
            mid();
            chk("str_fb_addr", fb_addr, str_addr[i]);
            chk("str_miss", vga_miss, 0);
            if (i > 0) chk("str_valid", vga_valid, 1);
        end
        tick();
        vga_req = 1'b0;
        mid();
        chk("str_last_valid", vga_valid, 1);
        chk("str_last_data", vga_data, 12'h5A5);
        tick();
        mid();
        chk("str_idle_valid", vga_valid, 0);
        chk("str_idle_hold", vga_data, 12'h5A5);
        chk("str_idle_miss", vga_miss, 0);

        // Reset during the response cycle
        tick();
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 17'h00123;
        mid();
        chk("rm_grant", fb_en, 1);
        tick();
        nreset = 1'b0;
        mid();
        chk("rm_no_ack", cpu_ack, 0);
        chk("rm_stall", cpu_stall_req, 1);
        tick();
        tick();
        nreset = 1'b1;
        cpu_q.push_back('{1'b1, 12'hABC});
        mid();
        chk("rm_regrant_en", fb_en, 1);
        chk("rm_regrant_addr", fb_addr, 17'h00123);
        chk("rm_regrant_noack", cpu_ack, 0);
        tick();
        mid();
        chk("rm_ack", cpu_ack, 1);
        tick();
        cpu_req = 1'b0;
        mid();

        // Fresh reset, then starvation with VGA continuously requesting
        tick();
        nreset = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        vga_req = 1'b1; vga_addr = 17'h00001;
        cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 17'h00123;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            vga_q.push_back(12'h002);
            mid();
            chk("stv_vga_served", fb_addr, 17'h00001);
            chk("stv_stall", cpu_stall_req, 1);
        end
        tick();
        cpu_q.push_back('{1'b1, 12'hABC});
        mid();
        chk("stv_force_addr", fb_addr, 17'h00123);
        chk("stv_force_en", fb_en, 1);
        chk("stv_force_stall", cpu_stall_req, 1);
        tick();
        vga_q.push_back(12'h002);
        mid();
        chk("stv_miss", vga_miss, 1);
        chk("stv_valid", vga_valid, 0);
        chk("stv_data_hold", vga_data, 12'h002);
        chk("stv_ack", cpu_ack, 1);
        chk("stv_vga_in_resp", fb_addr, 17'h00001);
        tick();
        cpu_req = 1'b0; vga_req = 1'b0;
        mid();
        chk("stv_after_valid", vga_valid, 1);
        chk("stv_after_miss", vga_miss, 0);
        tick();
        mid();
`ifdef FB_ACCESS_ARB_STATS_EN
        chk("stat_miss", stat_miss_cnt, 16'd1);
        chk("stat_stall", stat_stall_cnt, 16'd9);
`else
        chk("stat_miss_off", stat_miss_cnt, 16'd0);
        chk("stat_stall_off", stat_stall_cnt, 16'd0);
`endif
        chk("vga_q_drained", vga_q.size(), 0);
        chk("cpu_q_drained", cpu_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
